// File: rtl/rgb_seq_monitor.sv
// rgb_seq_monitor: checks the RGB blinker state/count stream and drives dimmed one-hot LEDs.
// Latency: error/locked/err_count/LEDs are registered, one cycle after the sample.
// Backpressure: none, every cycle's sample is consumed. Optional macro RGB_SEQ_STICKY_ERR_EN holds error until reset.
module rgb_seq_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int PWM_BITS = 4,
  parameter int DUTY     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] state_in,
  input  logic [3:0] count_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       locked,
  output logic       error,
  output logic [7:0] err_count
);

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b01;
  localparam logic [1:0] BLUE  = 2'b10;

  // Clamp DUTY so any value at or above a full period compares as always-on.
  localparam int PWM_PERIOD = 2 ** PWM_BITS;
  localparam int DUTY_CLAMP = (DUTY > PWM_PERIOD) ? PWM_PERIOD : ((DUTY < 0) ? 0 : DUTY);
  localparam logic [PWM_BITS:0] DUTY_CMP   = (PWM_BITS + 1)'(DUTY_CLAMP);
  localparam logic [3:0]        LOCK_LEN_C = 4'(LOCK_LEN);

  logic                have_prev_q, have_prev_d;
  logic [1:0]          prev_state_q, prev_state_d;
  logic [3:0]          prev_count_q, prev_count_d;
  logic [3:0]          match_run_q, match_run_d;
  logic                locked_q, locked_d;
  logic                error_q, error_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                led_r_q, led_r_d;
  logic                led_g_q, led_g_d;
  logic                led_b_q, led_b_d;

  logic       legal;
  logic [1:0] exp_state;
  logic [3:0] exp_count;
  logic       match;
  logic [3:0] run_inc;
  logic       violation;
  logic       pwm_on;

  // Classify the incoming pair and predict the successor of the stored previous pair.
  always_comb begin
    legal = 1'b0;
    case (state_in)
      RED:     legal = (count_in <= 4'd5);
      GREEN:   legal = (count_in >= 4'd6) && (count_in <= 4'd10);
      BLUE:    legal = (count_in >= 4'd11);
      default: legal = 1'b0;
    endcase

    exp_count = prev_count_q + 4'd1;
    case (prev_count_q)
      4'd5:    exp_state = GREEN;
      4'd10:   exp_state = BLUE;
      4'd15:   exp_state = RED;
      default: exp_state = prev_state_q;
    endcase

    match   = (state_in == exp_state) && (count_in == exp_count);
    run_inc = (match_run_q == 4'd15) ? 4'd15 : (match_run_q + 4'd1);
  end

  // Tracking next state: capture, match/mismatch bookkeeping, error and counters.
  always_comb begin
    have_prev_d  = have_prev_q;
    prev_state_d = prev_state_q;
    prev_count_d = prev_count_q;
    match_run_d  = match_run_q;
    locked_d     = locked_q;
    violation    = 1'b0;

    if (!legal) begin
      violation   = 1'b1;
      have_prev_d = 1'b0;
      match_run_d = 4'd0;
      locked_d    = 1'b0;
    end else begin
      // Every legal pair becomes the new reference, so a mismatch resyncs at once.
      prev_state_d = state_in;
      prev_count_d = count_in;
      have_prev_d  = 1'b1;
      if (have_prev_q) begin
        if (match) begin
          match_run_d = run_inc;
          if (run_inc >= LOCK_LEN_C) begin
            locked_d = 1'b1;
          end
        end else begin
          violation   = 1'b1;
          match_run_d = 4'd0;
          locked_d    = 1'b0;
        end
      end
    end

    err_count_d = (violation && (err_count_q != 8'hFF)) ? (err_count_q + 8'd1) : err_count_q;

`ifdef RGB_SEQ_STICKY_ERR_EN
    error_d = error_q | violation;
`else
    error_d = violation;
`endif
  end

  // PWM gate and LED drive; built from the next lock/prev values so LEDs are dark in any cycle locked is low.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = ({1'b0, pwm_cnt_q} < DUTY_CMP);
    led_r_d   = locked_d && (prev_state_d == RED)   && pwm_on;
    led_g_d   = locked_d && (prev_state_d == GREEN) && pwm_on;
    led_b_d   = locked_d && (prev_state_d == BLUE)  && pwm_on;
  end

  // State registers with synchronous reset; reset overrides any violation in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      have_prev_q  <= 1'b0;
      prev_state_q <= RED;
      prev_count_q <= 4'd0;
      match_run_q  <= 4'd0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      err_count_q  <= 8'd0;
      pwm_cnt_q    <= '0;
      led_r_q      <= 1'b0;
      led_g_q      <= 1'b0;
      led_b_q      <= 1'b0;
    end else begin
      have_prev_q  <= have_prev_d;
      prev_state_q <= prev_state_d;
      prev_count_q <= prev_count_d;
      match_run_q  <= match_run_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      err_count_q  <= err_count_d;
      pwm_cnt_q    <= pwm_cnt_d;
      led_r_q      <= led_r_d;
      led_g_q      <= led_g_d;
      led_b_q      <= led_b_d;
    end
  end

  assign led_r     = led_r_q;
  assign led_g     = led_g_q;
  assign led_b     = led_b_q;
  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;

endmodule
